// File: rtl/cache_def.sv
// -----------------------------------------------------------------------------
// cache_def
// Shared types for the risk-cache front end. cpu_req_type and cpu_result_type
// are the cache FSM request/result records; arb_state_type is the state set of
// the request arbiter that sits in front of the cache.
// -----------------------------------------------------------------------------
package cache_def;

  // Request from the CPU side into the cache FSM.
  typedef struct packed {
    logic [31:0] addr;   // byte address, clientID in bits [13:4]
    logic [31:0] data;   // write data (don't-care on reads)
    logic        rw;     // 1 = write, 0 = read
    logic        valid;  // request present
  } cpu_req_type;

  // Result from the cache FSM back to the CPU side.
  typedef struct packed {
    logic [31:0] data;   // read data (or value returned on write)
    logic        ready;  // result valid this cycle
  } cpu_result_type;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_type;

  // Width of a requester index; at least one bit so a single-requester build
  // still has a legal vector.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_req_arbiter_if
// Bundles the requester-side handshake, the response channel and the cache
// request/result records of cache_req_arbiter.
//   slave  : the arbiter (consumes requests and cache results)
//   master : requesters + cache model (drive requests and cache results)
// Signals:
//   req_valid/req_addr/req_data/req_rw  per-requester request
//   req_ready                           one-hot accept pulse
//   cpu_req / cpu_res                   cache FSM request / result
//   rsp_valid/rsp_id/rsp_data/rsp_err   response pulse and payload
//   busy                                arbiter not in IDLE
// -----------------------------------------------------------------------------
interface cache_req_arbiter_if
  import cache_def::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0][31:0] req_addr;
  logic [NUM_REQ-1:0][31:0] req_data;
  logic [NUM_REQ-1:0]       req_rw;
  logic [NUM_REQ-1:0]       req_ready;
  cpu_req_type              cpu_req;
  cpu_result_type           cpu_res;
  logic                     rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [31:0]              rsp_data;
  logic                     rsp_err;
  logic                     busy;

  modport slave (
    input  req_valid, req_addr, req_data, req_rw, cpu_res,
    output req_ready, cpu_req, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport master (
    output req_valid, req_addr, req_data, req_rw, cpu_res,
    input  req_ready, cpu_req, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

endinterface

// File: rtl/cache_rr_picker.sv
// -----------------------------------------------------------------------------
// cache_rr_picker
// Purely combinational round-robin selector. Searches req_valid starting at
// last_grant+1 (mod NUM_REQ) and returns the first set index; last_grant itself
// is considered last, which bounds starvation to NUM_REQ-1 other grants.
// Ports:
//   req_valid  [NUM_REQ]  pending requests
//   last_grant [ID_W]     index granted most recently
//   grant      [ID_W]     selected index (0 when nothing is pending)
//   any_valid             at least one request pending
// -----------------------------------------------------------------------------
module cache_rr_picker
  import cache_def::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    grant,
  output logic               any_valid
);

  // One extra bit so last_grant + offset never wraps before the modulo step.
  logic [ID_W:0] idx;

  // NOTE: every output and temporary of a combinational block gets a value
  // before any conditional logic, so no path can leave it unassigned and infer
  // a latch.
  always_comb begin
    grant     = '0;
    any_valid = |req_valid;
    idx       = '0;
    // Walk from the farthest offset to the nearest; the last hit wins, which
    // gives the nearest requester after last_grant highest priority.
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = {1'b0, last_grant} + (ID_W + 1)'(off);
      if (idx >= (ID_W + 1)'(NUM_REQ)) idx = idx - (ID_W + 1)'(NUM_REQ);
      if (req_valid[idx[ID_W-1:0]]) grant = idx[ID_W-1:0];
    end
  end

endmodule

// File: rtl/cache_req_arbiter.sv
// -----------------------------------------------------------------------------
// cache_req_arbiter
// Shares one risk-cache port among NUM_REQ requesters. FSM IDLE -> ISSUE ->
// RESP -> IDLE: a request is granted round-robin in IDLE, presented to the
// cache (fields held) in ISSUE until cpu_res.ready, and answered with a single
// rsp_valid pulse in RESP. cpu_req.valid is therefore low for at least two
// cycles between transactions.
// Ports:
//   clk, rst_n  single clock, asynchronous active-low reset
//   bus         cache_req_arbiter_if.slave (requests, cache, response, busy)
// Parameters:
//   NUM_REQ         number of requesters (default 4)
//   TIMEOUT_CYCLES  ISSUE watchdog limit (default 64, used with ARB_TIMEOUT_EN)
// Build option:
//   ARB_TIMEOUT_EN  when defined, a transaction stuck in ISSUE for
//                   TIMEOUT_CYCLES cycles is answered with rsp_err=1 and
//                   rsp_data=0; otherwise rsp_err is tied low and ISSUE waits
//                   indefinitely.
// -----------------------------------------------------------------------------
module cache_req_arbiter
  import cache_def::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic               clk,
  input logic               rst_n,
  cache_req_arbiter_if.slave bus
);

  localparam int ID_W = id_width(NUM_REQ);

  arb_state_type      state_q, state_d;
  logic [ID_W-1:0]    last_grant_q;
  logic [ID_W-1:0]    owner_q;
  logic [ID_W-1:0]    pick;
  logic               any_valid;
  logic               accept;
  logic               expire;
  logic [NUM_REQ-1:0] req_ready_d;
  logic [31:0]        addr_q;
  logic [31:0]        data_q;
  logic               rw_q;
  logic [31:0]        rsp_data_q;
  logic               rsp_err_q;

  cache_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_valid  (bus.req_valid),
    .last_grant (last_grant_q),
    .grant      (pick),
    .any_valid  (any_valid)
  );

  // req_ready is a same-cycle (Mealy) pulse, so it is gated with rst_n to
  // stay low while reset is asserted even if requests are pending.
  assign accept = (state_q == IDLE) && any_valid && rst_n;

`ifdef ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] timer_q;

  // Counts cycles spent in ISSUE; held at zero elsewhere so it is clear on
  // every entry to ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 timer_q <= '0;
    else if (state_q != ISSUE)  timer_q <= '0;
    else                        timer_q <= timer_q + TMR_W'(1);
  end

  // High during the TIMEOUT_CYCLES-th ISSUE cycle; cpu_res.ready in that same
  // cycle takes precedence in the FSM below.
  assign expire = (state_q == ISSUE) && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  // Next-state and accept pulse.
  always_comb begin
    state_d     = state_q;
    req_ready_d = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          req_ready_d[pick] = 1'b1;
          state_d           = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.cpu_res.ready || expire) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, independent of the
  // order of statements in the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      owner_q      <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      rw_q         <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q <= pick;
            addr_q  <= bus.req_addr[pick];
            data_q  <= bus.req_data[pick];
            rw_q    <= bus.req_rw[pick];
          end
        end
        ISSUE: begin
          if (bus.cpu_res.ready) begin
            rsp_data_q <= bus.cpu_res.data;
            rsp_err_q  <= 1'b0;
          end else if (expire) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
        RESP: begin
          last_grant_q <= owner_q;
          rsp_err_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = req_ready_d;
  assign bus.cpu_req   = '{addr: addr_q, data: data_q, rw: rw_q, valid: (state_q == ISSUE)};
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = owner_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cache_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_req_arbiter
// Directed bench for cache_req_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=8). A table
// of transactions (pending mask, cache stall, cache data, expected grant) is
// replayed through one task; reset, spurious cache ready, the ISSUE watchdog
// (or its absence) and reset mid-ISSUE are hand-written sequences.
// Inputs are driven and outputs sampled just after the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cache_req_arbiter;
  import cache_def::*;

  localparam int NUM_REQ = 4;

  typedef struct {
    logic [3:0]  valid;   // req_valid applied in IDLE
    int          stall;   // ISSUE cycles with cpu_res.ready low
    logic [31:0] cdata;   // data returned by the cache
    int          exp_g;   // expected granted requester
    bit          hold;    // keep req_valid of the winner high after accept
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [31:0] addr_tab [NUM_REQ];
  logic [31:0] data_tab [NUM_REQ];
  logic [3:0]  rw_bits;
  vec_t        tbl [12];

  cache_req_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  cache_req_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one transaction. Entered just after a falling edge with the DUT in
  // IDLE; leaves just after the falling edge of the following IDLE cycle.
  task automatic run_row(input vec_t v);
    cpu_req_type snap;
    bit          stable;
    logic [3:0]  exp_rdy;
    exp_rdy = 4'b0001 << v.exp_g;
    bus.req_valid = v.valid;
    #1;
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("req_ready_onehot", 32'(bus.req_ready), 32'(exp_rdy));
    @(negedge clk);
    if (!v.hold) bus.req_valid[v.exp_g] = 1'b0;
    #1;
    check("issue_ready_low", 32'(bus.req_ready), 32'd0);
    check("issue_valid", 32'(bus.cpu_req.valid), 32'd1);
    check("issue_addr", bus.cpu_req.addr, addr_tab[v.exp_g]);
    check("issue_data", bus.cpu_req.data, data_tab[v.exp_g]);
    check("issue_rw", 32'(bus.cpu_req.rw), 32'(rw_bits[v.exp_g]));
    snap   = bus.cpu_req;
    stable = 1'b1;
    repeat (v.stall) begin
      @(negedge clk);
      #1;
      if (bus.cpu_req !== snap || bus.rsp_valid !== 1'b0) stable = 1'b0;
    end
    check("issue_stable", 32'(stable), 32'd1);
    bus.cpu_res = '{data: v.cdata, ready: 1'b1};
    @(negedge clk);
    bus.cpu_res = '{data: ~v.cdata, ready: 1'b0};
    #1;
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_id", 32'(bus.rsp_id), 32'(v.exp_g));
    check("rsp_data", bus.rsp_data, v.cdata);
    check("rsp_err", 32'(bus.rsp_err), 32'd0);
    check("resp_cpu_valid", 32'(bus.cpu_req.valid), 32'd0);
    check("resp_ready_low", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    #1;
    check("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    bit seen_rsp;
    n_checks = 0;
    n_errors = 0;
    rw_bits  = 4'b1010;
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_tab[i]      = 32'h10 * (i + 1);
      data_tab[i]      = 32'hD000_0000 + i;
      bus.req_addr[i]  = addr_tab[i];
      bus.req_data[i]  = data_tab[i];
    end
    bus.req_rw    = rw_bits;
    bus.req_valid = '0;
    bus.cpu_res   = '{data: 32'h0, ready: 1'b0};

    //          valid    stall cdata          g  hold
    tbl[0]  = '{4'b0100, 2,  32'hCAFE_0030, 2, 1'b0};  // single read, addr 0x30
    tbl[1]  = '{4'b1000, 10, 32'h1234_5678, 3, 1'b0};  // write miss, long stall
    tbl[2]  = '{4'b0011, 0,  32'hA5A5_0001, 0, 1'b0};  // wraps past 3 to 0
    tbl[3]  = '{4'b0011, 1,  32'hA5A5_0002, 1, 1'b0};
    tbl[4]  = '{4'b0101, 0,  32'hA5A5_0003, 2, 1'b0};
    tbl[5]  = '{4'b0001, 3,  32'hA5A5_0004, 0, 1'b0};
    tbl[6]  = '{4'b0100, 1,  32'h0BAD_F00D, 2, 1'b0};  // after watchdog case
    tbl[7]  = '{4'b1111, 0,  32'h1111_0000, 0, 1'b1};  // contention from reset
    tbl[8]  = '{4'b1111, 1,  32'h1111_0001, 1, 1'b1};
    tbl[9]  = '{4'b1111, 0,  32'h1111_0002, 2, 1'b1};
    tbl[10] = '{4'b1111, 2,  32'h1111_0003, 3, 1'b1};
    tbl[11] = '{4'b1111, 0,  32'h1111_0004, 0, 1'b1};

    // Reset state.
    rst_n = 1'b0;
    #3;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_cpu_valid", 32'(bus.cpu_req.valid), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i <= 5; i++) run_row(tbl[i]);

    // Spurious cache ready in IDLE.
    bus.cpu_res = '{data: 32'h5555_AAAA, ready: 1'b1};
    repeat (3) begin
      @(negedge clk);
      #1;
      check("spur_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("spur_busy", 32'(bus.busy), 32'd0);
    end
    bus.cpu_res = '{data: 32'h0, ready: 1'b0};

    // Cache never answers.
    bus.req_valid = 4'b0001;
    #1;
    check("stuck_ready", 32'(bus.req_ready), 32'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("stuck_issue", 32'(bus.cpu_req.valid), 32'd1);
`ifdef ARB_TIMEOUT_EN
    seen_rsp = 1'b0;
    repeat (7) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid) seen_rsp = 1'b1;
    end
    check("to_no_early_rsp", 32'(seen_rsp), 32'd0);
    check("to_still_issue", 32'(bus.cpu_req.valid), 32'd1);
    @(negedge clk);
    #1;
    check("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("to_rsp_err", 32'(bus.rsp_err), 32'd1);
    check("to_rsp_data", bus.rsp_data, 32'd0);
    check("to_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("to_cpu_valid", 32'(bus.cpu_req.valid), 32'd0);
    @(negedge clk);
    #1;
    check("to_idle", 32'(bus.busy), 32'd0);
    check("to_err_clear", 32'(bus.rsp_err), 32'd0);
`else
    seen_rsp = 1'b0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid || bus.rsp_err) seen_rsp = 1'b1;
    end
    check("wait_no_rsp", 32'(seen_rsp), 32'd0);
    check("wait_busy", 32'(bus.busy), 32'd1);
    check("wait_cpu_valid", 32'(bus.cpu_req.valid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
`endif
    run_row(tbl[6]);

    // Reset mid-ISSUE, requests pending throughout.
    bus.req_valid = 4'b0010;
    #1;
    check("mid_ready", 32'(bus.req_ready), 32'b0010);
    @(negedge clk);
    #1;
    check("mid_issue", 32'(bus.cpu_req.valid), 32'd1);
    rst_n         = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_cpu_valid", 32'(bus.cpu_req.valid), 32'd0);
    check("mid_rst_cpu_addr", bus.cpu_req.addr, 32'd0);
    check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("mid_rst_rsp_data", bus.rsp_data, 32'd0);
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_post_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    for (int i = 7; i <= 11; i++) run_row(tbl[i]);
    bus.req_valid = '0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
